// File: rtl/cmd_queue.sv
// Multi-source command queue: one pending slot per source, fixed-priority
// arbitration into a FIFO with optional drop-oldest overwrite when full.
module cmd_queue #(
    parameter int DEPTH     = 16,
    parameter int NSRC      = 2,
    parameter int CMD_W     = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NSRC-1:0]          i_src_valid,
    input  logic [NSRC*CMD_W-1:0]    i_src_cmd,
    output logic [NSRC-1:0]          o_src_ready,
    input  logic                     i_flush,
    input  logic                     i_pop,
    output logic [CMD_W-1:0]         o_head_cmd,
    output logic                     o_head_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic [7:0]               o_drop_cnt,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW:0]      r_count;
    logic [NSRC-1:0]  r_pend_v;
    logic [CMD_W-1:0] r_pend_cmd [NSRC];
    logic [7:0]       r_drop_cnt;
    logic             r_overflow;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_found;
    logic [NSRC-1:0]  w_grant;
    logic [CMD_W-1:0] w_grant_cmd;
    logic             w_push;
    logic             w_ow_drop;
    logic [NSRC-1:0]  w_new_cmd;
    logic [NSRC-1:0]  w_slot_drop;
    logic [3:0]       w_drops;
    logic [8:0]       w_drop_sum;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_pop     = i_pop && !w_empty && !i_flush;

    // Lowest-index occupied slot wins; one grant per cycle at most.
    always_comb begin
        w_grant     = '0;
        w_grant_cmd = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_pend_v[i] && !w_found) begin
                w_grant[i]  = 1'b1;
                w_grant_cmd = r_pend_cmd[i];
                w_found     = 1'b1;
            end
        end
    end

    assign w_push    = w_found && !i_flush && (!w_full || w_pop || (OVERWRITE != 0));
    assign w_ow_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_drops = {3'b000, w_ow_drop};
        for (int i = 0; i < NSRC; i++) begin
            w_new_cmd[i]   = i_src_valid[i] && (i_src_cmd[i*CMD_W +: CMD_W] != '0);
            w_slot_drop[i] = w_new_cmd[i] && r_pend_v[i] && !i_flush;
            w_drops        = w_drops + {3'b000, w_slot_drop[i]};
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + {5'b00000, w_drops};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pend_v   <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_pend_v <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                // An overwrite push retires the head to make room, so count holds.
                if (w_pop || w_ow_drop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_ow_drop && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
                for (int i = 0; i < NSRC; i++) begin
                    if (w_grant[i] && w_push) begin
                        r_pend_v[i] <= 1'b0;
                    end else if (w_new_cmd[i] && !r_pend_v[i]) begin
                        r_pend_v[i]   <= 1'b1;
                        r_pend_cmd[i] <= i_src_cmd[i*CMD_W +: CMD_W];
                    end
                end
            end
            if (w_drops != '0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_grant_cmd;
        end
    end

    assign o_src_ready  = ~r_pend_v;
    assign o_head_valid = !w_empty;
    assign o_head_cmd   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count      = r_count;
    assign o_full       = w_full;
    assign o_drop_cnt   = r_drop_cnt;
    assign o_overflow   = r_overflow;

endmodule
